dl_ram_wr_ctrl_mb: RTL and testbench
====================================

// Module: dl_ram_wr_ctrl_mb
// PURPOSE
//  Downlink frame writer: hunts SYNC_COUNT consecutive SYNC_BYTE words, then writes one frame into a free bank of a multi-bank RAM.
//  Generalises the two-bank ping-pong writer: N banks, parametrised frame/sync length, round-robin bank pick, per-bank length and drop accounting.
//  Sits between the McBSP byte unpacker (upstream) and the 8b/10b encoder/RAM reader (downstream).
// PARAMETERS
//  DATA_W       8        data word width
//  NUM_BANKS    2        number of RAM banks, 2..8
//  BANK_DEPTH   64       address stride per bank (power of 2); bank b base = b*BANK_DEPTH
//  FRAME_LEN    38       words per full frame incl. sync words; must be <= BANK_DEPTH
//  SYNC_BYTE    8'h47    sync word value
//  SYNC_COUNT   2        consecutive sync words required, 1..4
//  TIMEOUT_MAX  100000   idle cycles in WRITE before a partial frame is flushed
//  DONE_HOLD    8        cycles spent in DONE before re-arming
// PORTS
//  clk           in   1                      system clock
//  rst           in   1                      synchronous reset, active-high
//  in_data       in   DATA_W                 upstream word
//  in_data_en    in   1                      upstream word valid, one-cycle strobe
//  bank_rd_done  in   NUM_BANKS              reader pulse: bank b consumed, free it
//  wr_addr       out  ADDR_W                 RAM write address, ADDR_W = $clog2(NUM_BANKS*BANK_DEPTH)
//  wr_data       out  DATA_W                 RAM/encoder write data
//  wr_en         out  1                      RAM write / encoder single-word enable
//  wr_active     out  1                      high while a frame is being captured (sync matched .. DONE exit)
//  bank_full     out  NUM_BANKS              bank b holds an unread frame
//  bank_len      out  NUM_BANKS*LEN_W        words stored per bank, LEN_W = $clog2(FRAME_LEN+1)
//  frame_done    out  1                      one-cycle pulse on DONE entry
//  timeout_flush out  1                      one-cycle pulse when a frame closed by timeout
//  drop_cnt      out  16                     frames dropped for lack of a free bank
// BEHAVIOUR
//  Reset: every output 0; state IDLE; round-robin pointer 0; timeout counter 0.
//  Latency: wr_en/wr_addr/wr_data registered, one cycle after the accepted in_data_en.
//  States: IDLE -> SYNC -> WRITE -> DONE -> IDLE; DROP is a sub-mode of SYNC (counts, writes nothing).
//  IDLE: in_data_en && in_data==SYNC_BYTE -> sync_cnt=1; bank chosen now = first free bank at/after rr pointer.
//    No free bank: drop mode, no writes this frame. SYNC_COUNT==1 goes straight to WRITE (or back to IDLE if dropping).
//  SYNC: each sync word is written at base+sync_cnt-1; on reaching SYNC_COUNT -> WRITE, or -> IDLE with drop_cnt+1 if dropping.
//    Non-sync valid word -> IDLE; already-written words are abandoned, bank stays free. Cycles without in_data_en hold state.
//  WRITE: each valid word written at base+offset, offset+1. The word at offset FRAME_LEN-1 -> DONE, bank_len=FRAME_LEN.
//  Timeout: counter cleared by in_data_en or outside WRITE; reaching TIMEOUT_MAX in WRITE -> DONE, timeout_flush=1, bank_len=offset.
//  DONE entry: bank_full[b] set, frame_done pulse, rr pointer = b+1 mod NUM_BANKS; stay DONE_HOLD cycles, inputs ignored.
//  bank_full[b] cleared by bank_rd_done[b]. Same-cycle set and clear of one bank -> set wins. bank_len[b] holds until next write to b.
//  A bank being captured is never selected again until freed. rd_done on a non-full bank is ignored.
//  drop_cnt saturates at 16'hFFFF. rst mid-frame aborts the frame; no partial bank_full is raised.
// CONFIGURATION
//  DL_WR_DROP_CNT_EN defined: drop_cnt counts as above.
//  DL_WR_DROP_CNT_EN undefined: drop_cnt tied to 0, counter not built; drop behaviour is otherwise unchanged.
// STRUCTURE
//  Package dl_ram_pkg: state enum (IDLE/SYNC/WRITE/DONE), default SYNC_BYTE, LEN_W/ADDR_W helper functions.
//  Sub-module dl_bank_alloc: bank_full flags, set/clear arbitration, round-robin first-free search, any_free output.
// TESTING
//  47,47,36 data words (N=2) -> bank0 written 0..37, frame_done once, bank_full=01, bank_len0=38.
//  Second frame while bank0 full -> base 64, bank_full=11; third frame -> drop_cnt=1, no wr_en after the sync words.
//  47,12 -> back to IDLE, no bank_full; then 47,47,... captured normally into bank0.
//  47,47 + 10 words, then TIMEOUT_MAX idle cycles -> timeout_flush, bank_len=12, bank_full set.
//  bank_rd_done[0] pulsed in the same cycle bank0 is re-filled -> bank_full[0] stays 1; rst mid-WRITE -> all outputs 0.
//  NUM_BANKS=4, SYNC_COUNT=3: banks filled 0,1,2,3; free bank1 -> next frame goes to bank1 (round-robin).

Source files
------------

// File: rtl/dl_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dl_ram_pkg
// Purpose  : Shared types and width helpers for the downlink multi-bank RAM
//            frame writer (state encoding, default sync word, width math).
// Revision : 1.0 - initial release
// ============================================================================
package dl_ram_pkg;

    // Writer FSM states; frame drop is a flag carried alongside ST_SYNC.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dl_state_e;

    localparam logic [7:0] C_SYNC_BYTE_DEF = 8'h47;

    // Width of a per-bank length field able to hold 0..frame_len.
    function automatic int len_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Width of the flat RAM write address across all banks.
    function automatic int addr_w(input int num_banks, input int bank_depth);
        return $clog2(num_banks * bank_depth);
    endfunction

    // Width of a bank index (at least one bit).
    function automatic int idx_w(input int num_banks);
        return (num_banks < 2) ? 1 : $clog2(num_banks);
    endfunction

endpackage : dl_ram_pkg
`default_nettype wire

// File: rtl/dl_bank_alloc.sv
`default_nettype none
// ============================================================================
// Module   : dl_bank_alloc
// Purpose  : Bank occupancy flags for the downlink writer. Sets a bank's
//            full flag when a frame closes, clears it on the reader's done
//            pulse (set wins on collision), and finds the first free bank at
//            or after the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module dl_bank_alloc
    import dl_ram_pkg::*;
#(
    parameter int NUM_BANKS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [idx_w(NUM_BANKS)-1:0]      rr_ptr,
    input  logic                             set_en,
    input  logic [idx_w(NUM_BANKS)-1:0]      set_idx,
    input  logic [NUM_BANKS-1:0]             clr_vec,
    output logic [NUM_BANKS-1:0]             bank_full,
    output logic [idx_w(NUM_BANKS)-1:0]      free_idx,
    output logic                             any_free
);

    localparam int C_IDX_W = idx_w(NUM_BANKS);

    logic [NUM_BANKS-1:0] full_q;
    logic [NUM_BANKS-1:0] full_d;
    logic [NUM_BANKS-1:0] w_set_vec;

    // Next flags: clear consumed banks, then apply the set so it dominates.
    always_comb begin
        w_set_vec = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_set_vec[i] = set_en && (set_idx == C_IDX_W'(i));
        end
        full_d = (full_q & ~clr_vec) | w_set_vec;
    end

    // Round-robin search: walk offsets from rr_ptr, wrapping at NUM_BANKS.
    always_comb begin
        logic [C_IDX_W:0] sum;
        logic [C_IDX_W-1:0] cand;
        sum      = '0;
        cand     = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            sum = {1'b0, rr_ptr} + (C_IDX_W + 1)'(i);
            if (sum >= (C_IDX_W + 1)'(NUM_BANKS)) begin
                sum = sum - (C_IDX_W + 1)'(NUM_BANKS);
            end
            cand = sum[C_IDX_W-1:0];
            for (int j = 0; j < NUM_BANKS; j++) begin
                if (!any_free && !full_q[j] && (cand == C_IDX_W'(j))) begin
                    any_free = 1'b1;
                    free_idx = cand;
                end
            end
        end
    end

    // Occupancy flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    assign bank_full = full_q;

endmodule : dl_bank_alloc
`default_nettype wire

// File: rtl/dl_ram_wr_ctrl_mb.sv
`default_nettype none
// ============================================================================
// Module   : dl_ram_wr_ctrl_mb
// Purpose  : Downlink frame writer. Hunts SYNC_COUNT consecutive SYNC_BYTE
//            words, then writes one frame into a free bank of a multi-bank
//            RAM (round-robin pick), with per-bank length, idle-timeout
//            flush and dropped-frame accounting.
// Config   : DL_WR_DROP_CNT_EN - when defined, drop_cnt counts frames lost
//            for lack of a free bank; otherwise drop_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dl_ram_wr_ctrl_mb
    import dl_ram_pkg::*;
#(
    parameter int                 DATA_W      = 8,
    parameter int                 NUM_BANKS   = 2,
    parameter int                 BANK_DEPTH  = 64,
    parameter int                 FRAME_LEN   = 38,
    parameter logic [DATA_W-1:0]  SYNC_BYTE   = DATA_W'(C_SYNC_BYTE_DEF),
    parameter int                 SYNC_COUNT  = 2,
    parameter int                 TIMEOUT_MAX = 100000,
    parameter int                 DONE_HOLD   = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_W-1:0]                         in_data,
    input  logic                                      in_data_en,
    input  logic [NUM_BANKS-1:0]                      bank_rd_done,
    output logic [addr_w(NUM_BANKS, BANK_DEPTH)-1:0]  wr_addr,
    output logic [DATA_W-1:0]                         wr_data,
    output logic                                      wr_en,
    output logic                                      wr_active,
    output logic [NUM_BANKS-1:0]                      bank_full,
    output logic [NUM_BANKS*len_w(FRAME_LEN)-1:0]     bank_len,
    output logic                                      frame_done,
    output logic                                      timeout_flush,
    output logic [15:0]                               drop_cnt
);

    localparam int C_ADDR_W = addr_w(NUM_BANKS, BANK_DEPTH);
    localparam int C_LEN_W  = len_w(FRAME_LEN);
    localparam int C_IDX_W  = idx_w(NUM_BANKS);
    localparam int C_OFF_W  = $clog2(BANK_DEPTH);
    localparam int C_TMO_W  = $clog2(TIMEOUT_MAX + 1);
    localparam int C_HOLD_W = $clog2(DONE_HOLD + 1);

    localparam logic [2:0]          C_SYNC_LAST = 3'(SYNC_COUNT);
    localparam logic [C_LEN_W-1:0]  C_LEN_FULL  = C_LEN_W'(FRAME_LEN);
    localparam logic [C_LEN_W-1:0]  C_LAST_OFF  = C_LEN_W'(FRAME_LEN - 1);
    localparam logic [C_TMO_W-1:0]  C_TMO_LAST  = C_TMO_W'(TIMEOUT_MAX - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(DONE_HOLD - 1);
    localparam logic [C_IDX_W-1:0]  C_IDX_LAST  = C_IDX_W'(NUM_BANKS - 1);

    dl_state_e              state_q, state_d;
    logic [2:0]             sync_cnt_q, sync_cnt_d;
    logic                   drop_q, drop_d;
    logic [C_IDX_W-1:0]     bank_q, bank_d;
    logic [C_LEN_W-1:0]     offset_q, offset_d;
    logic [C_TMO_W-1:0]     tmo_q, tmo_d;
    logic [C_HOLD_W-1:0]    hold_q, hold_d;
    logic [C_IDX_W-1:0]     rr_q, rr_d;
    logic                   wr_en_q, wr_en_d;
    logic [C_ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   wr_active_q, wr_active_d;
    logic                   frame_done_q, frame_done_d;
    logic                   timeout_flush_q, timeout_flush_d;
    logic [C_LEN_W-1:0]     bank_len_q [NUM_BANKS];
    logic [C_LEN_W-1:0]     bank_len_d [NUM_BANKS];

    logic                   w_set_en;
    logic                   w_len_we;
    logic [C_LEN_W-1:0]     w_len_val;
    logic                   w_drop_inc;
    logic [C_IDX_W-1:0]     w_free_idx;
    logic                   w_any_free;

    // Bank base is a power of two, so the address is {bank, offset}.
    function automatic logic [C_ADDR_W-1:0] mk_addr(input logic [C_IDX_W-1:0] b,
                                                    input logic [C_LEN_W-1:0] off);
        return C_ADDR_W'({b, C_OFF_W'(off)});
    endfunction

    dl_bank_alloc #(
        .NUM_BANKS (NUM_BANKS)
    ) u_alloc (
        .clk       (clk),
        .rst       (rst),
        .rr_ptr    (rr_q),
        .set_en    (w_set_en),
        .set_idx   (bank_q),
        .clr_vec   (bank_rd_done),
        .bank_full (bank_full),
        .free_idx  (w_free_idx),
        .any_free  (w_any_free)
    );

    // Next-state, write strobes and frame-close bookkeeping.
    always_comb begin
        state_d         = state_q;
        sync_cnt_d      = sync_cnt_q;
        drop_d          = drop_q;
        bank_d          = bank_q;
        offset_d        = offset_q;
        tmo_d           = '0;
        hold_d          = hold_q;
        rr_d            = rr_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        frame_done_d    = 1'b0;
        timeout_flush_d = 1'b0;
        w_set_en        = 1'b0;
        w_len_we        = 1'b0;
        w_len_val       = offset_q;
        w_drop_inc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_data_en && (in_data == SYNC_BYTE)) begin
                    sync_cnt_d = 3'd1;
                    drop_d     = !w_any_free;
                    bank_d     = w_free_idx;
                    offset_d   = C_LEN_W'(1);
                    if (w_any_free) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = mk_addr(w_free_idx, '0);
                        wr_data_d = in_data;
                    end
                    if (SYNC_COUNT == 1) begin
                        if (w_any_free) begin
                            state_d = ST_WRITE;
                        end else begin
                            drop_d     = 1'b0;
                            w_drop_inc = 1'b1;
                        end
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
            end

            ST_SYNC: begin
                if (in_data_en) begin
                    if (in_data == SYNC_BYTE) begin
                        sync_cnt_d = sync_cnt_q + 3'd1;
                        offset_d   = offset_q + C_LEN_W'(1);
                        if (!drop_q) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = mk_addr(bank_q, offset_q);
                            wr_data_d = in_data;
                        end
                        if ((sync_cnt_q + 3'd1) == C_SYNC_LAST) begin
                            if (drop_q) begin
                                state_d    = ST_IDLE;
                                drop_d     = 1'b0;
                                w_drop_inc = 1'b1;
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end
                    end else begin
                        // Broken sync run: abandon partial writes, bank stays free.
                        state_d = ST_IDLE;
                        drop_d  = 1'b0;
                    end
                end
            end

            ST_WRITE: begin
                if (in_data_en) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = mk_addr(bank_q, offset_q);
                    wr_data_d = in_data;
                    if (offset_q == C_LAST_OFF) begin
                        state_d      = ST_DONE;
                        hold_d       = '0;
                        w_set_en     = 1'b1;
                        frame_done_d = 1'b1;
                        w_len_we     = 1'b1;
                        w_len_val    = C_LEN_FULL;
                        rr_d         = (bank_q == C_IDX_LAST) ? '0 : bank_q + C_IDX_W'(1);
                    end else begin
                        offset_d = offset_q + C_LEN_W'(1);
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    // Idle budget exhausted: close the partial frame as-is.
                    state_d         = ST_DONE;
                    hold_d          = '0;
                    w_set_en        = 1'b1;
                    frame_done_d    = 1'b1;
                    timeout_flush_d = 1'b1;
                    w_len_we        = 1'b1;
                    w_len_val       = offset_q;
                    rr_d            = (bank_q == C_IDX_LAST) ? '0 : bank_q + C_IDX_W'(1);
                end else begin
                    tmo_d = tmo_q + C_TMO_W'(1);
                end
            end

            ST_DONE: begin
                if (hold_q == C_HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + C_HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_active_d = (state_d != ST_IDLE) && !drop_d;
    end

    // Per-bank stored length, updated only when that bank's frame closes.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_len_d[i] = (w_len_we && (bank_q == C_IDX_W'(i))) ? w_len_val : bank_len_q[i];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sync_cnt_q      <= '0;
            drop_q          <= 1'b0;
            bank_q          <= '0;
            offset_q        <= '0;
            tmo_q           <= '0;
            hold_q          <= '0;
            rr_q            <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_active_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            timeout_flush_q <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_len_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            sync_cnt_q      <= sync_cnt_d;
            drop_q          <= drop_d;
            bank_q          <= bank_d;
            offset_q        <= offset_d;
            tmo_q           <= tmo_d;
            hold_q          <= hold_d;
            rr_q            <= rr_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_active_q     <= wr_active_d;
            frame_done_q    <= frame_done_d;
            timeout_flush_q <= timeout_flush_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_len_q[i] <= bank_len_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_len
            assign bank_len[g*C_LEN_W +: C_LEN_W] = bank_len_q[g];
        end
    endgenerate

`ifdef DL_WR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of frames lost for lack of a free bank.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic w_unused_drop_inc;
    assign w_unused_drop_inc = w_drop_inc;
    assign drop_cnt          = 16'h0000;
`endif

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_active     = wr_active_q;
    assign frame_done    = frame_done_q;
    assign timeout_flush = timeout_flush_q;

endmodule : dl_ram_wr_ctrl_mb
`default_nettype wire

// File: tb/tb_dl_ram_wr_ctrl_mb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dl_ram_wr_ctrl_mb
// Purpose  : Self-checking bench for dl_ram_wr_ctrl_mb. A two-bank instance
//            runs a frame table; a four-bank, three-sync instance checks the
//            round-robin pick. RAM writes are checked against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dl_ram_wr_ctrl_mb;

    localparam int D_TMO   = 40;
    localparam int D_HOLD  = 8;
    localparam int Q_TMO   = 40;
    localparam int Q_HOLD  = 4;
`ifdef DL_WR_DROP_CNT_EN
    localparam int C_DROP1 = 1;
`else
    localparam int C_DROP1 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Two-bank instance (default geometry)
    logic [7:0]  d_in_data = '0;
    logic        d_in_en   = 1'b0;
    logic [1:0]  d_rd_done = '0;
    logic [6:0]  d_wr_addr;
    logic [7:0]  d_wr_data;
    logic        d_wr_en, d_wr_active, d_frame_done, d_timeout_flush;
    logic [1:0]  d_bank_full;
    logic [11:0] d_bank_len;
    logic [15:0] d_drop_cnt;

    // Four-bank instance
    logic [7:0]  q_in_data = '0;
    logic        q_in_en   = 1'b0;
    logic [3:0]  q_rd_done = '0;
    logic [5:0]  q_wr_addr;
    logic [7:0]  q_wr_data;
    logic        q_wr_en, q_wr_active, q_frame_done, q_timeout_flush;
    logic [3:0]  q_bank_full;
    logic [15:0] q_bank_len;
    logic [15:0] q_drop_cnt;

    dl_ram_wr_ctrl_mb #(
        .TIMEOUT_MAX (D_TMO), .DONE_HOLD (D_HOLD)
    ) dut (
        .clk (clk), .rst (rst), .in_data (d_in_data), .in_data_en (d_in_en),
        .bank_rd_done (d_rd_done), .wr_addr (d_wr_addr), .wr_data (d_wr_data),
        .wr_en (d_wr_en), .wr_active (d_wr_active), .bank_full (d_bank_full),
        .bank_len (d_bank_len), .frame_done (d_frame_done),
        .timeout_flush (d_timeout_flush), .drop_cnt (d_drop_cnt)
    );

    dl_ram_wr_ctrl_mb #(
        .NUM_BANKS (4), .BANK_DEPTH (16), .FRAME_LEN (8), .SYNC_COUNT (3),
        .TIMEOUT_MAX (Q_TMO), .DONE_HOLD (Q_HOLD)
    ) dut4 (
        .clk (clk), .rst (rst), .in_data (q_in_data), .in_data_en (q_in_en),
        .bank_rd_done (q_rd_done), .wr_addr (q_wr_addr), .wr_data (q_wr_data),
        .wr_en (q_wr_en), .wr_active (q_wr_active), .bank_full (q_bank_full),
        .bank_len (q_bank_len), .frame_done (q_frame_done),
        .timeout_flush (q_timeout_flush), .drop_cnt (q_drop_cnt)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb0[$];
    wr_t sb1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_done0 = 0, n_tmo0 = 0, n_done1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitors: every wr_en must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (d_wr_en) begin
            if (sb0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr0_unexpected: got write addr %0h data %0h, expected no write", d_wr_addr, d_wr_data);
            end else begin
                e = sb0.pop_front();
                check("wr0_addr", 32'(d_wr_addr), 32'(e.addr));
                check("wr0_data", 32'(d_wr_data), 32'(e.data));
            end
        end
        if (q_wr_en) begin
            if (sb1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr1_unexpected: got write addr %0h data %0h, expected no write", q_wr_addr, q_wr_data);
            end else begin
                e = sb1.pop_front();
                check("wr1_addr", 32'(q_wr_addr), 32'(e.addr));
                check("wr1_data", 32'(q_wr_data), 32'(e.data));
            end
        end
        if (d_frame_done)    n_done0++;
        if (d_timeout_flush) n_tmo0++;
        if (q_frame_done)    n_done1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sb_push(input bit which, input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = 16'(addr);
        e.data = data;
        if (which) sb1.push_back(e);
        else       sb0.push_back(e);
    endtask

    task automatic send_word(input bit which, input logic [7:0] d, input logic [3:0] rd);
        if (which) begin
            q_in_data = d; q_in_en = 1'b1; q_rd_done = rd;
        end else begin
            d_in_data = d; d_in_en = 1'b1; d_rd_done = rd[1:0];
        end
        tick();
        q_in_en = 1'b0; q_rd_done = '0;
        d_in_en = 1'b0; d_rd_done = '0;
    endtask

    task automatic pulse_rd(input bit which, input logic [3:0] mask);
        if (which) q_rd_done = mask;
        else       d_rd_done = mask[1:0];
        tick();
        q_rd_done = '0;
        d_rd_done = '0;
    endtask

    task automatic send_syncs(input bit which, input int n, input int bank, input int depth, input bit push);
        for (int s = 0; s < n; s++) begin
            if (push) sb_push(which, bank * depth + s, 8'h47);
            send_word(which, 8'h47, 4'h0);
        end
    endtask

    task automatic send_data(input bit which, input int n, input int off0, input int bank,
                             input int depth, input bit push, input int seed, input logic [3:0] last_rd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'((seed + i) % 64);
            if (push) sb_push(which, bank * depth + off0 + i, d);
            send_word(which, d, (i == n - 1) ? last_rd : 4'h0);
        end
    endtask

    typedef struct {
        logic [1:0] rd_pre;
        bit         bad_sync;
        int         n_data;
        int         exp_bank;
        bit         drop_mode;
        logic [1:0] exp_full;
        int         exp_len0;
        int         exp_len1;
        int         exp_drops;
        int         exp_done;
        int         exp_tmo;
    } row_t;

    row_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rd_pre, bad, n_data, bank, drop, full, len0, len1, drops, done, tmo
        tbl[0] = '{2'b00, 1'b0, 36, 0, 1'b0, 2'b01, 38,  0, 0,       1, 0};
        tbl[1] = '{2'b00, 1'b0, 36, 1, 1'b0, 2'b11, 38, 38, 0,       1, 0};
        tbl[2] = '{2'b00, 1'b0, 36, 0, 1'b1, 2'b11, 38, 38, C_DROP1, 0, 0};
        tbl[3] = '{2'b11, 1'b1,  0, 0, 1'b0, 2'b00, 38, 38, C_DROP1, 0, 0};
        tbl[4] = '{2'b00, 1'b0, 36, 0, 1'b0, 2'b01, 38, 38, C_DROP1, 1, 0};
        tbl[5] = '{2'b00, 1'b0, 10, 1, 1'b0, 2'b11, 38, 12, C_DROP1, 1, 1};

        wait_ticks(3);
        rst = 1'b0;
        tick();
        check("rst_wr_en",     32'(d_wr_en), 0);
        check("rst_wr_addr",   32'(d_wr_addr), 0);
        check("rst_wr_active", 32'(d_wr_active), 0);
        check("rst_bank_full", 32'(d_bank_full), 0);
        check("rst_bank_len",  32'(d_bank_len), 0);
        check("rst_drop_cnt",  32'(d_drop_cnt), 0);

        for (int r = 0; r < 6; r++) begin
            row_t t;
            int done_base;
            int tmo_base;
            int k;
            bit seen;
            t = tbl[r];
            done_base = n_done0;
            tmo_base  = n_tmo0;
            if (t.rd_pre != 2'b00) pulse_rd(1'b0, {2'b00, t.rd_pre});
            if (t.bad_sync) begin
                if (!t.drop_mode) sb_push(1'b0, t.exp_bank * 64, 8'h47);
                send_word(1'b0, 8'h47, 4'h0);
                check("row_active_sync1", 32'(d_wr_active), 32'(!t.drop_mode));
                send_word(1'b0, 8'h12, 4'h0);
                check("row_active_broken", 32'(d_wr_active), 0);
                wait_ticks(12);
            end else begin
                send_syncs(1'b0, 2, t.exp_bank, 64, !t.drop_mode);
                check("row_active_synced", 32'(d_wr_active), 32'(!t.drop_mode));
                send_data(1'b0, t.n_data, 2, t.exp_bank, 64, !t.drop_mode, r * 5, 4'h0);
                if (t.exp_tmo != 0) begin
                    k = 0;
                    seen = 1'b0;
                    while (!seen && k < D_TMO + 20) begin
                        tick();
                        k++;
                        if (d_timeout_flush) seen = 1'b1;
                    end
                    check("tmo_latency", 32'(k), 32'(D_TMO));
                    wait_ticks(D_HOLD + 4);
                end else begin
                    wait_ticks(12);
                end
            end
            check("row_active_idle", 32'(d_wr_active), 0);
            check("row_bank_full",   32'(d_bank_full), 32'(t.exp_full));
            check("row_bank_len0",   32'(d_bank_len[5:0]), 32'(t.exp_len0));
            check("row_bank_len1",   32'(d_bank_len[11:6]), 32'(t.exp_len1));
            check("row_drop_cnt",    32'(d_drop_cnt), 32'(t.exp_drops));
            check("row_frame_done",  32'(n_done0 - done_base), 32'(t.exp_done));
            check("row_tmo_flush",   32'(n_tmo0 - tmo_base), 32'(t.exp_tmo));
        end

        // Free bank0, refill it while the reader pulses done for bank0 on the closing word.
        pulse_rd(1'b0, 4'b0001);
        check("free0_full", 32'(d_bank_full), 32'h2);
        send_syncs(1'b0, 2, 0, 64, 1'b1);
        send_data(1'b0, 36, 2, 0, 64, 1'b1, 11, 4'b0001);
        wait_ticks(12);
        check("setwins_full", 32'(d_bank_full), 32'h3);

        // Reset in the middle of a frame into bank1.
        pulse_rd(1'b0, 4'b0011);
        send_syncs(1'b0, 2, 1, 64, 1'b1);
        send_data(1'b0, 5, 2, 1, 64, 1'b1, 20, 4'h0);
        check("midframe_active", 32'(d_wr_active), 1);
        tick();
        rst = 1'b1;
        wait_ticks(2);
        check("rstmid_wr_en",     32'(d_wr_en), 0);
        check("rstmid_wr_addr",   32'(d_wr_addr), 0);
        check("rstmid_wr_data",   32'(d_wr_data), 0);
        check("rstmid_wr_active", 32'(d_wr_active), 0);
        check("rstmid_bank_full", 32'(d_bank_full), 0);
        check("rstmid_bank_len",  32'(d_bank_len), 0);
        check("rstmid_done_tmo",  32'({d_frame_done, d_timeout_flush}), 0);
        check("rstmid_drop_cnt",  32'(d_drop_cnt), 0);
        rst = 1'b0;
        tick();
        send_syncs(1'b0, 2, 0, 64, 1'b1);
        send_data(1'b0, 36, 2, 0, 64, 1'b1, 30, 4'h0);
        wait_ticks(12);
        check("postrst_full", 32'(d_bank_full), 32'h1);
        check("postrst_len0", 32'(d_bank_len[5:0]), 38);

        // Four banks, three sync words: fill 0..3, free bank1, expect bank1 next.
        for (int b = 0; b < 4; b++) begin
            send_syncs(1'b1, 3, b, 16, 1'b1);
            send_data(1'b1, 5, 3, b, 16, 1'b1, b * 3, 4'h0);
            wait_ticks(Q_HOLD + 4);
        end
        check("q_full_all", 32'(q_bank_full), 32'hF);
        check("q_done_cnt", 32'(n_done1), 4);
        pulse_rd(1'b1, 4'b0010);
        check("q_free1", 32'(q_bank_full), 32'hD);
        send_syncs(1'b1, 3, 1, 16, 1'b1);
        send_data(1'b1, 5, 3, 1, 16, 1'b1, 40, 4'h0);
        wait_ticks(Q_HOLD + 4);
        check("q_full_rr", 32'(q_bank_full), 32'hF);
        check("q_len1",    32'(q_bank_len[7:4]), 8);
        check("q_done_rr", 32'(n_done1), 5);

        wait_ticks(3);
        check("sb0_drained", 32'(sb0.size()), 0);
        check("sb1_drained", 32'(sb1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dl_ram_wr_ctrl_mb
`default_nettype wire
